// File: rtl/attestation_client_if.sv
// Link and host-side bundle for the attestation client.
// master: the attestation client (drives tx_*, resp_*, key_ready, bs_ready, status).
// slave:  the environment (responder link, host sources, control and status sink).
//   start/abort/bs_size_bytes : session control
//   tx_data/tx_valid          : words to the responder
//   rx_data/rx_valid          : words from the responder
//   resp_data/resp_valid/resp_done : forwarded CERT_RESPONSE payload
//   key_data/key_valid/key_ready   : CLIENT_KEY payload source
//   bs_data/bs_valid/bs_ready      : bitstream source (hash, IV, ciphertext)
//   busy/done/fail/fail_code       : session status
`timescale 1ns/1ps
interface attestation_client_if;
    logic        start;
    logic        abort;
    logic [31:0] bs_size_bytes;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] resp_data;
    logic        resp_valid;
    logic        resp_done;
    logic [31:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_ready;
    logic        busy;
    logic        done;
    logic        fail;
    logic [2:0]  fail_code;

    modport master (
        input  start, abort, bs_size_bytes, rx_data, rx_valid,
        input  key_data, key_valid, bs_data, bs_valid,
        output tx_data, tx_valid, resp_data, resp_valid, resp_done,
        output key_ready, bs_ready, busy, done, fail, fail_code
    );

    modport slave (
        output start, abort, bs_size_bytes, rx_data, rx_valid,
        output key_data, key_valid, bs_data, bs_valid,
        input  tx_data, tx_valid, resp_data, resp_valid, resp_done,
        input  key_ready, bs_ready, busy, done, fail, fail_code
    );
endinterface

// File: rtl/attestation_client.sv
// Initiator end of the attestation / bitstream-provisioning session. Sends AUTH_REQUEST,
// forwards the CERT_RESPONSE payload to the host, streams CLIENT_KEY and then the encrypted
// bitstream from host-side sources, and reports the responder's final verdict.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : attestation_client_if.master (link, host sources, control, status)
// All outputs are registered.
`timescale 1ns/1ps
module attestation_client #(
    parameter int unsigned RESP_WORDS     = 1280,
    parameter int unsigned KEY_WORDS      = 256,
    parameter int unsigned KEY_GAP_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  reset_n,
    attestation_client_if.master bus
);

    localparam logic [31:0] MsgAuthRequest  = 32'h0000_0001;
    localparam logic [31:0] MsgCertResponse = 32'h0000_0002;
    localparam logic [31:0] MsgClientKey    = 32'h0000_0003;
    localparam logic [31:0] MsgBitstream    = 32'h0000_0004;
    localparam logic [31:0] MsgAuthComplete = 32'h0000_0005;
    localparam logic [31:0] MsgError        = 32'hFFFF_FFFF;

    localparam logic [31:0] RespWords   = 32'(RESP_WORDS);
    localparam logic [31:0] KeyLast     = 32'(KEY_WORDS) - 32'd1;
    localparam logic [31:0] GapLast     = 32'(KEY_GAP_CYCLES) - 32'd1;
    localparam logic [31:0] TimeoutMax  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] BsPreWords  = 32'd12;  // 8 hash + 4 IV words

    localparam logic [2:0] FailNone          = 3'd0;
    localparam logic [2:0] FailCertTimeout   = 3'd1;
    localparam logic [2:0] FailPeerError     = 3'd2;
    localparam logic [2:0] FailResultTimeout = 3'd3;
    localparam logic [2:0] FailAbort         = 3'd4;
    localparam logic [2:0] FailBadResult     = 3'd5;

    // Header-emitting phases get their own states so each header lands in the cycle
    // after entry and the payload follows without a bubble.
    typedef enum logic [3:0] {
        StIdle,
        StSendReq,
        StWaitCert,
        StRecvCert,
        StSendKey,
        StKeyData,
        StGap,
        StSendBs,
        StBsSize,
        StBsData,
        StWaitResult,
        StDone,
        StFail
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] bs_size_q, bs_size_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_done_q, resp_done_d;
    logic        key_ready_q, key_ready_d;
    logic        bs_ready_q, bs_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [2:0]  fail_code_q, fail_code_d;

    logic        go_fail;
    logic [2:0]  go_fail_code;
    logic        peer_error;
    logic        in_busy;
    logic [31:0] timer_inc;
    logic [31:0] bs_last;

    assign peer_error = bus.rx_valid && (bus.rx_data == MsgError);
    assign in_busy    = !(state_q inside {StIdle, StDone, StFail});
    assign timer_inc  = timer_q + 32'd1;
    assign bs_last    = (bs_size_q >> 2) + BsPreWords - 32'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        bs_size_d    = bs_size_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        resp_done_d  = 1'b0;
        key_ready_d  = key_ready_q;
        bs_ready_d   = bs_ready_q;
        fail_code_d  = fail_code_q;
        go_fail      = 1'b0;
        go_fail_code = FailNone;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.start) begin
                    bs_size_d   = bus.bs_size_bytes;
                    fail_code_d = FailNone;
                    tx_data_d   = MsgAuthRequest;
                    tx_valid_d  = 1'b1;
                    state_d     = StSendReq;
                end
            end
            StSendReq: begin
                timer_d = '0;
                state_d = StWaitCert;
            end
            StWaitCert: begin
                if (bus.rx_valid) begin
                    timer_d = '0;
                    if (bus.rx_data == MsgCertResponse) begin
                        cnt_d   = '0;
                        state_d = StRecvCert;
                    end else if (bus.rx_data == MsgError) begin
                        go_fail      = 1'b1;
                        go_fail_code = FailPeerError;
                    end
                end else if (timer_inc == TimeoutMax) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailCertTimeout;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StRecvCert: begin
                if (cnt_q == RespWords) begin
                    resp_done_d = 1'b1;
                    state_d     = StSendKey;
                end else if (bus.rx_valid) begin
                    resp_data_d  = bus.rx_data;
                    resp_valid_d = 1'b1;
                    cnt_d        = cnt_q + 32'd1;
                    timer_d      = '0;
                end else if (timer_inc == TimeoutMax) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailCertTimeout;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StSendKey: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else begin
                    tx_data_d   = MsgClientKey;
                    tx_valid_d  = 1'b1;
                    key_ready_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StKeyData;
                end
            end
            StKeyData: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else if (key_ready_q && bus.key_valid) begin
                    tx_data_d  = bus.key_data;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_q + 32'd1;
                    // Drop ready on the final handshake so no extra word is accepted.
                    if (cnt_q == KeyLast) begin
                        key_ready_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = StGap;
                    end
                end
            end
            StGap: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StSendBs;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StSendBs: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else begin
                    tx_data_d  = MsgBitstream;
                    tx_valid_d = 1'b1;
                    state_d    = StBsSize;
                end
            end
            StBsSize: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else begin
                    tx_data_d  = bs_size_q;
                    tx_valid_d = 1'b1;
                    bs_ready_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StBsData;
                end
            end
            StBsData: begin
                if (peer_error) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailPeerError;
                end else if (bs_ready_q && bus.bs_valid) begin
                    tx_data_d  = bus.bs_data;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_q + 32'd1;
                    if (cnt_q == bs_last) begin
                        bs_ready_d = 1'b0;
                        timer_d    = '0;
                        state_d    = StWaitResult;
                    end
                end
            end
            StWaitResult: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == MsgAuthComplete) begin
                        state_d = StDone;
                    end else if (bus.rx_data == MsgError) begin
                        go_fail      = 1'b1;
                        go_fail_code = FailPeerError;
                    end else begin
                        go_fail      = 1'b1;
                        go_fail_code = FailBadResult;
                    end
                end else if (timer_inc == TimeoutMax) begin
                    go_fail      = 1'b1;
                    go_fail_code = FailResultTimeout;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort outranks every other event of the cycle.
        if (bus.abort && in_busy) begin
            go_fail      = 1'b1;
            go_fail_code = FailAbort;
        end

        // Any failure kills the streams at once: nothing further leaves the block.
        if (go_fail) begin
            state_d      = StFail;
            fail_code_d  = go_fail_code;
            tx_valid_d   = 1'b0;
            resp_valid_d = 1'b0;
            resp_done_d  = 1'b0;
            key_ready_d  = 1'b0;
            bs_ready_d   = 1'b0;
        end
    end

    // Status flags follow the next state so they change together with it.
    always_comb begin
        busy_d = !(state_d inside {StIdle, StDone, StFail});
        done_d = (state_d == StDone);
        fail_d = (state_d == StFail);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            timer_q      <= '0;
            bs_size_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_done_q  <= 1'b0;
            key_ready_q  <= 1'b0;
            bs_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= FailNone;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            bs_size_q    <= bs_size_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            resp_done_q  <= resp_done_d;
            key_ready_q  <= key_ready_d;
            bs_ready_q   <= bs_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_done  = resp_done_q;
    assign bus.key_ready  = key_ready_q;
    assign bus.bs_ready   = bs_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.fail_code  = fail_code_q;

endmodule

// File: tb/tb_attestation_client.sv
// Directed bench for attestation_client: responder and host sources are driven from here,
// and a per-cycle compare process checks the link and forwarded payload against
// queues of expected words built from the protocol description.
`timescale 1ns/1ps
module tb_attestation_client;

    localparam int unsigned RespWords = 1280;
    localparam int unsigned KeyWords  = 256;
    localparam int unsigned GapCycles = 64;
    localparam int unsigned Timeout   = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    attestation_client_if bus ();

    attestation_client #(
        .RESP_WORDS    (RespWords),
        .KEY_WORDS     (KeyWords),
        .KEY_GAP_CYCLES(GapCycles),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] word;
        int          gap;  // required idle cycles before this word, -1 = any
        bit          src;  // word comes from a host source handshake
    } tx_exp_t;

    tx_exp_t     exp_tx[$];
    logic [31:0] exp_resp[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_tx_cyc = 0;
    int resp_done_cnt = 0;
    int key_idx = 0;
    int bs_idx = 0;
    bit stall = 1'b0;
    bit silent = 1'b0;

    function automatic logic [31:0] key_word(int i);
        return 32'hA500_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] bs_word(int i);
        return 32'hB600_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] resp_word(int i);
        return 32'hC700_0000 + 32'(i);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic rx_send(logic [31:0] w);
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_tx(logic [31:0] w, int g, bit s);
        tx_exp_t e;
        e.word = w;
        e.gap  = g;
        e.src  = s;
        exp_tx.push_back(e);
    endtask

    task automatic compare_loop();
        int idle_run = 0;
        bit prev_hs = 1'b0;
        bit prev_rv = 1'b0;
        tx_exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_valid) begin
                last_tx_cyc = cyc;
                if (silent || exp_tx.size() == 0) begin
                    check("tx_unexpected_valid", 32'(bus.tx_valid), 32'd0);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_word", bus.tx_data, e.word);
                    if (e.gap >= 0) check("tx_gap", 32'(idle_run), 32'(e.gap));
                    if (e.src) check("tx_after_handshake", 32'(prev_hs), 32'd1);
                end
                idle_run = 0;
            end else begin
                idle_run++;
                if (prev_hs && !silent) check("tx_missing_after_hs", 32'(bus.tx_valid), 32'd1);
            end
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                else check("resp_word", bus.resp_data, exp_resp.pop_front());
            end
            if (bus.resp_done) begin
                resp_done_cnt++;
                check("resp_done_after_last", 32'(prev_rv), 32'd1);
                check("resp_done_all_words", 32'(exp_resp.size()), 32'd0);
            end
            prev_rv = bus.resp_valid;
            prev_hs = (bus.key_valid && bus.key_ready) || (bus.bs_valid && bus.bs_ready);
        end
    endtask

    task automatic source_loop();
        bit phase = 1'b0;
        bit khs, bhs;
        bus.key_data  = key_word(0);
        bus.key_valid = 1'b1;
        bus.bs_data   = bs_word(0);
        bus.bs_valid  = 1'b1;
        forever begin
            @(negedge clk);
            khs = bus.key_valid && bus.key_ready;
            bhs = bus.bs_valid && bus.bs_ready;
            @(posedge clk);
            #1;
            if (khs) key_idx++;
            if (bhs) bs_idx++;
            phase = !phase;
            bus.key_data  = key_word(key_idx);
            bus.key_valid = stall ? phase : 1'b1;
            bus.bs_data   = bs_word(bs_idx);
            bus.bs_valid  = stall ? phase : 1'b1;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_tx_data"}, bus.tx_data, 32'd0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_resp_data"}, bus.resp_data, 32'd0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_done"}, 32'(bus.resp_done), 32'd0);
        check({tag, "_key_ready"}, 32'(bus.key_ready), 32'd0);
        check({tag, "_bs_ready"}, 32'(bus.bs_ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_fail"}, 32'(bus.fail), 32'd0);
        check({tag, "_fail_code"}, 32'(bus.fail_code), 32'd0);
    endtask

    // Builds the expected link traffic for one session and pulses start.
    task automatic start_session(logic [31:0] size, bit with_stream, int exp_len);
        int nbs;
        exp_tx.delete();
        push_tx(32'h1, -1, 1'b0);
        if (with_stream) begin
            push_tx(32'h3, -1, 1'b0);
            for (int i = 0; i < int'(KeyWords); i++) push_tx(key_word(key_idx + i), stall ? -1 : 0, 1'b1);
            push_tx(32'h4, int'(GapCycles), 1'b0);
            push_tx(size, 0, 1'b0);
            nbs = 12 + int'(size / 4);
            for (int i = 0; i < nbs; i++) push_tx(bs_word(bs_idx + i), stall ? -1 : 0, 1'b1);
        end
        check("model_tx_len", 32'(exp_tx.size()), 32'(exp_len));
        silent = 1'b0;
        bus.bs_size_bytes = size;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("start_tx_word", bus.tx_data, 32'h1);
        check("start_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic send_cert(int words);
        idle(3);
        rx_send(32'h0000_1234);  // stray word, must be ignored while waiting
        rx_send(32'h2);
        for (int i = 0; i < words; i++) begin
            if (i == 100) idle(5);
            exp_resp.push_back(resp_word(i));
            rx_send(resp_word(i));
        end
    endtask

    task automatic wait_stream(int budget);
        int n = 0;
        while (exp_tx.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("stream_complete", 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic run_full(logic [31:0] size, bit stall_mode, logic [31:0] result,
                            int exp_code, int exp_len, int exp_bs_hs);
        int kb, bb, rd;
        stall = stall_mode;
        kb = key_idx;
        bb = bs_idx;
        rd = resp_done_cnt;
        start_session(size, 1'b1, exp_len);
        send_cert(int'(RespWords));
        wait_stream(4000);
        idle(2);
        rx_send(result);
        check("end_done", 32'(bus.done), 32'(exp_code == 0));
        check("end_fail", 32'(bus.fail), 32'(exp_code != 0));
        check("end_fail_code", 32'(bus.fail_code), 32'(exp_code));
        check("end_busy", 32'(bus.busy), 32'd0);
        check("key_handshakes", 32'(key_idx - kb), 32'(KeyWords));
        check("bs_handshakes", 32'(bs_idx - bb), 32'(exp_bs_hs));
        check("resp_done_pulses", 32'(resp_done_cnt - rd), 32'd1);
        stall = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int kb, bb, b1, n, rd, target;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.bs_size_bytes = '0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        fork
            compare_loop();
            source_loop();
        join_none

        // Reset state
        #2 reset_n = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Nominal session, then stalled sources, then zero-size bitstream with bad verdict
        run_full(32'd64, 1'b0, 32'h5, 0, 288, 28);
        run_full(32'd64, 1'b1, 32'h5, 0, 288, 28);
        run_full(32'd0, 1'b0, 32'h7, 5, 272, 12);

        // Peer error in the middle of the bitstream
        bb = bs_idx;
        start_session(32'd64, 1'b1, 288);
        send_cert(int'(RespWords));
        n = 0;
        while ((bs_idx - bb) < 10 && n < 3000) begin
            tick();
            n++;
        end
        check("perr_reached_bs", 32'((bs_idx - bb) >= 10), 32'd1);
        rx_send(32'hFFFF_FFFF);
        silent = 1'b1;
        exp_tx.delete();
        tick();
        b1 = bs_idx;
        idle(20);
        check("perr_fail", 32'(bus.fail), 32'd1);
        check("perr_fail_code", 32'(bus.fail_code), 32'd2);
        check("perr_busy", 32'(bus.busy), 32'd0);
        check("perr_bs_ready", 32'(bus.bs_ready), 32'd0);
        check("perr_stream_stopped", 32'(bs_idx), 32'(b1));

        // No certificate: timeout after 100 idle cycles following the request
        start_session(32'd0, 1'b0, 1);
        idle(int'(Timeout));
        check("cert_to_not_yet", 32'(bus.fail), 32'd0);
        tick();
        check("cert_to_fail", 32'(bus.fail), 32'd1);
        check("cert_to_code", 32'(bus.fail_code), 32'd1);
        check("cert_to_busy", 32'(bus.busy), 32'd0);

        // No verdict: timer starts when the last bitstream word goes out
        start_session(32'd64, 1'b1, 288);
        send_cert(int'(RespWords));
        wait_stream(4000);
        target = last_tx_cyc + int'(Timeout) - 2;
        n = 0;
        while (cyc < target && n < 500) begin
            tick();
            n++;
        end
        check("res_to_not_yet", 32'(bus.fail), 32'd0);
        tick();
        check("res_to_fail", 32'(bus.fail), 32'd1);
        check("res_to_code", 32'(bus.fail_code), 32'd3);

        // Abort during certificate reception, coinciding with an rx word
        rd = resp_done_cnt;
        start_session(32'd64, 1'b0, 1);
        idle(2);
        rx_send(32'h2);
        for (int i = 0; i < 50; i++) begin
            exp_resp.push_back(resp_word(i));
            rx_send(resp_word(i));
        end
        bus.abort = 1'b1;
        bus.rx_data = resp_word(50);
        bus.rx_valid = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.rx_valid = 1'b0;
        for (int i = 51; i < 56; i++) rx_send(resp_word(i));
        idle(3);
        check("abort_fail", 32'(bus.fail), 32'd1);
        check("abort_code", 32'(bus.fail_code), 32'd4);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_no_resp_done", 32'(resp_done_cnt - rd), 32'd0);
        check("abort_resp_forwarded", 32'(exp_resp.size()), 32'd0);

        // Asynchronous reset in the middle of the key stream
        kb = key_idx;
        start_session(32'd64, 1'b1, 288);
        send_cert(int'(RespWords));
        n = 0;
        while ((key_idx - kb) < 20 && n < 3000) begin
            tick();
            n++;
        end
        check("rst_reached_key", 32'((key_idx - kb) >= 20), 32'd1);
        silent = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        idle(2);
        exp_tx.delete();
        exp_resp.delete();
        reset_n = 1'b1;
        idle(2);
        check_reset_outputs("postrst");

        // Full session after reset
        run_full(32'd64, 1'b0, 32'h5, 0, 288, 28);

        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/attestation_client.md
# attestation_client

Initiator end of the FPGA attestation and bitstream-provisioning protocol. It sequences one full session over the shared 32-bit word link:

- sends AUTH_REQUEST;
- captures and forwards the CERT_RESPONSE payload;
- streams CLIENT_KEY and then ENCRYPTED_BITSTREAM from host-side sources;
- reports the responder's final AUTH_COMPLETE or ERROR.

It sits in the provisioning controller opposite the on-FPGA security agent. All cryptography is done by the host; this block only moves words.

## Interface
- RESP_WORDS, 1280: CERT_RESPONSE payload words after the header (nonce 64, ECDHE public key 128, signature 64, certificate 1024).
- KEY_WORDS, 256: CLIENT_KEY payload words after the header (nonce 64, public key 128, signature 64).
- KEY_GAP_CYCLES, 64: idle cycles after the last CLIENT_KEY word before the bitstream header is sent.
- TIMEOUT_CYCLES, 1000000: maximum wait for any expected responder word.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session when in IDLE, DONE or FAIL.
- abort  in  1  forces FAIL (code 4) from any busy state.
- bs_size_bytes  in  32  ciphertext byte count; sampled on start; multiple of 4.
- tx_data  out  32  link word to responder.
- tx_valid  out  1  tx_data valid this cycle.
- rx_data  in  32  link word from responder.
- rx_valid  in  1  rx_data valid this cycle.
- resp_data  out  32  forwarded CERT_RESPONSE payload word.
- resp_valid  out  1  resp_data valid.
- resp_done  out  1  one-cycle pulse after the last payload word is forwarded.
- key_data  in  32  CLIENT_KEY payload source.
- key_valid  in  1  source valid.
- key_ready  out  1  source ready.
- bs_data  in  32  bitstream source: 8 hash words, 4 IV words, then bs_size_bytes/4 ciphertext words.
- bs_valid  in  1  source valid.
- bs_ready  out  1  source ready.
- busy  out  1  high in every state except IDLE, DONE, FAIL.
- done  out  1  level, high in DONE.
- fail  out  1  level, high in FAIL.
- fail_code  out  3  0 none, 1 certificate timeout, 2 peer ERROR, 3 result timeout, 4 abort, 5 bad result word.

## Operation

**Link rules**
- The link has no backpressure: one word per cycle when valid.

**States and transitions**
- IDLE: on start, load the size register and go to SEND_REQ.
- SEND_REQ: emit 0x00000001 for one cycle, then go to WAIT_CERT.
- WAIT_CERT:
  - rx word 0x00000002 → RECV_CERT, word counter cleared.
  - rx word 0xFFFFFFFF → FAIL, code 2.
  - Any other word is discarded.
- RECV_CERT:
  - Each rx_valid word is copied to resp_data/resp_valid and increments the counter.
  - After RESP_WORDS words: pulse resp_done and go to SEND_KEY.
  - Gaps between words are permitted; the timeout applies per gap.
- SEND_KEY:
  - First emits header 0x00000003.
  - Then key_ready=1 until KEY_WORDS handshakes have completed; each handshake emits key_data.
  - Then go to GAP.
  - key_valid is expected to rise only once the host has validated the certificate.
- GAP: count KEY_GAP_CYCLES, then go to SEND_BS.
- SEND_BS:
  - Emit header 0x00000004, then bs_size_bytes.
  - Then bs_ready=1 for 12 + bs_size_bytes/4 handshakes; each handshake emits bs_data.
  - Then go to WAIT_RESULT.
- WAIT_RESULT:
  - 0x00000005 → DONE.
  - 0xFFFFFFFF → FAIL, code 2.
  - Any other word → FAIL, code 5.
- DONE / FAIL: hold until start (new session) or reset.

**Timeout and abort**
- A 32-bit timer is cleared on entry to WAIT_CERT, RECV_CERT and WAIT_RESULT, and on every rx_valid.
- If it reaches TIMEOUT_CYCLES: FAIL with code 1 (WAIT_CERT/RECV_CERT) or code 3 (WAIT_RESULT).
- 0xFFFFFFFF received in any state from SEND_KEY through SEND_BS → FAIL, code 2, and the stream stops immediately.
- abort has priority over every other event in the same cycle.
- Counters are 32-bit. Payload counters compare with ==, never wrap.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - tx_data 0, tx_valid 0;
  - resp_data 0, resp_valid 0, resp_done 0;
  - key_ready 0, bs_ready 0;
  - busy 0, done 0, fail 0, fail_code 0.
- start → first tx_valid (request word): 1 cycle.
- A source handshake in cycle N puts that word on tx_data/tx_valid in cycle N+1.
- key_ready and bs_ready drop in the same cycle the final handshake completes, so there is no extra handshake.
- Header words are emitted in the cycle after state entry. With a continuously valid source, output is back-to-back with no bubbles.
- rx_valid in cycle N → resp_valid in cycle N+1. resp_done is in the cycle after the last resp_valid.
- bs_size_bytes = 0 is legal: only the hash and IV words (12) are streamed.
- start while busy is ignored.
- Asynchronous reset mid-session returns to IDLE with all outputs at their reset values; no partial message completion.

## Test plan
- **Nominal session:** start; responder returns 0x2 plus 1280 words; key source gives 256 words; bs_size_bytes = 64. Expect:
  - tx sequence: 0x1, then 0x3 plus 256 words, then 64 idle cycles, then 0x4, 0x40, 28 words;
  - rx 0x5 → done=1, busy=0.
- **Source stalls:** toggle key_valid and bs_valid every other cycle. Expect the tx word order to be unchanged, tx_valid only on the cycle after each handshake, and exactly 256 and 28 handshakes.
- **Peer error:** inject 0xFFFFFFFF mid-SEND_BS. Expect fail=1, fail_code=2, and no further tx_valid.
- **Timeout:** with TIMEOUT_CYCLES=100 and no response after the request, expect fail_code=1 at the 100th idle cycle. Repeat in WAIT_RESULT and expect code 3.
- **Bad result word:** rx 0x7 in WAIT_RESULT → fail_code=5.
- **Abort and reset:** abort during RECV_CERT → fail_code=4, resp_done never pulses. Reset mid-SEND_KEY → all outputs at reset values. A subsequent start runs a full nominal session.
